w_r16_bank_wr_gen: RTL and testbench

Radix-16 write-back scheduler for the banked coefficient memory. It accepts one group of 16 butterfly outputs per handshake and assigns each lane to one of 16 SRAM banks using a conflict-free digit-sum rotation. For every bank it drives the select, write-enable, address and data inputs of that bank's 16:1 write mux. The block sits directly upstream of the 16 per-bank write muxes, one registered stage ahead of them.

---
 rtl/w_r16_bank_wr_gen_if.sv | 27 ++
 rtl/w_r16_bank_wr_gen.sv | 120 ++++++++++++
 tb/tb_w_r16_bank_wr_gen.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/w_r16_bank_wr_gen_if.sv
// Group-input handshake and per-bank write-mux drive bundle for the radix-16 write-back scheduler.
// master = producer/observer side, slave = the scheduler itself.
interface w_r16_bank_wr_gen_if #(
    parameter int MA_width = 8,
    parameter int D_width  = 16
);
    logic                     start;
    logic                     in_valid;
    logic                     in_ready;
    logic [16*D_width-1:0]    in_data;
    logic [16*MA_width-1:0]   A_lane;
    logic [16*D_width-1:0]    D_lane;
    logic [16*5-1:0]          sel_bank;
    logic [15:0]              w_enable_bank;
    logic                     busy;
    logic                     done;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, A_lane, D_lane, sel_bank, w_enable_bank, busy, done
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, A_lane, D_lane, sel_bank, w_enable_bank, busy, done
    );
endinterface

// File: rtl/w_r16_bank_wr_gen.sv
// Radix-16 write-back scheduler: rotates each accepted group of 16 lanes onto the 16 SRAM banks
// by the base-16 digit sum of the group index, one registered stage ahead of the bank write muxes.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting groups 0..GROUPS-1
// DONE  | final group presented to the banks, one cycle
module w_r16_bank_wr_gen #(
    parameter int GROUPS   = 16,
    parameter int MA_width = 8,
    parameter int D_width  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    w_r16_bank_wr_gen_if.slave bus
);
    localparam int NIB = (MA_width + 3) / 4;
    localparam logic [MA_width-1:0] G_LAST = MA_width'(GROUPS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [MA_width-1:0]     g_q, g_d;
    logic                    accept;
    logic [NIB*4-1:0]        g_pad;
    logic [3:0]              rot;

    logic [16*MA_width-1:0]  a_lane_q, a_lane_d;
    logic [16*D_width-1:0]   d_lane_q, d_lane_d;
    logic [16*5-1:0]         sel_bank_q, sel_bank_d;
    logic [15:0]             w_enable_q, w_enable_d;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            g_q     <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
        end
    end

    // next-state
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    g_d     = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.in_valid) begin
                    g_d = g_q + 1'b1;
                    if (g_q == G_LAST) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.in_ready = (state_q == S_RUN);
        bus.busy     = (state_q != S_IDLE);
        bus.done     = (state_q == S_DONE);
        accept       = bus.in_valid && (state_q == S_RUN);
    end

    // Digit-sum rotation wraps at 4 bits, so the sum is already mod 16.
    always_comb begin
        g_pad = '0;
        g_pad[MA_width-1:0] = g_q;
        rot = 4'd0;
        for (int i = 0; i < NIB; i++) begin
            rot = rot + g_pad[i*4 +: 4];
        end
    end

    always_comb begin
        a_lane_d   = a_lane_q;
        d_lane_d   = d_lane_q;
        w_enable_d = 16'h0000;
        sel_bank_d = '0;
        for (int b = 0; b < 16; b++) begin
            sel_bank_d[b*5 +: 5] = accept ? {1'b0, 4'(b) - rot} : 5'd16;
        end
        if (accept) begin
            a_lane_d   = {16{g_q}};
            d_lane_d   = bus.in_data;
            w_enable_d = 16'hFFFF;
        end
    end

    // Idle select value 16 is what turns the bank's chip enable off downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_lane_q   <= '0;
            d_lane_q   <= '0;
            w_enable_q <= 16'h0000;
            for (int b = 0; b < 16; b++) begin
                sel_bank_q[b*5 +: 5] <= 5'd16;
            end
        end else begin
            a_lane_q   <= a_lane_d;
            d_lane_q   <= d_lane_d;
            w_enable_q <= w_enable_d;
            sel_bank_q <= sel_bank_d;
        end
    end

    assign bus.A_lane        = a_lane_q;
    assign bus.D_lane        = d_lane_q;
    assign bus.sel_bank      = sel_bank_q;
    assign bus.w_enable_bank = w_enable_q;
endmodule

// File: tb/tb_w_r16_bank_wr_gen.sv
// Randomized bench for the radix-16 write-back scheduler: two instances (16 and 32 groups per pass)
// share one stimulus stream and are compared every cycle against a digit-sum reference model.
module tb_w_r16_bank_wr_gen;
    localparam int MAW = 8;
    localparam int DW  = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              start_s    = 1'b0;
    logic              in_valid_s = 1'b0;
    logic [16*DW-1:0]  in_data_s  = '0;

    w_r16_bank_wr_gen_if #(.MA_width(MAW), .D_width(DW)) bus_a ();
    w_r16_bank_wr_gen_if #(.MA_width(MAW), .D_width(DW)) bus_b ();

    assign bus_a.start    = start_s;
    assign bus_a.in_valid = in_valid_s;
    assign bus_a.in_data  = in_data_s;
    assign bus_b.start    = start_s;
    assign bus_b.in_valid = in_valid_s;
    assign bus_b.in_data  = in_data_s;

    w_r16_bank_wr_gen #(.GROUPS(16), .MA_width(MAW), .D_width(DW)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    w_r16_bank_wr_gen #(.GROUPS(32), .MA_width(MAW), .D_width(DW)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    logic               o_ready [2];
    logic               o_busy  [2];
    logic               o_done  [2];
    logic [16*MAW-1:0]  o_a     [2];
    logic [16*DW-1:0]   o_d     [2];
    logic [79:0]        o_sel   [2];
    logic [15:0]        o_wen   [2];

    assign o_ready[0] = bus_a.in_ready;      assign o_ready[1] = bus_b.in_ready;
    assign o_busy[0]  = bus_a.busy;          assign o_busy[1]  = bus_b.busy;
    assign o_done[0]  = bus_a.done;          assign o_done[1]  = bus_b.done;
    assign o_a[0]     = bus_a.A_lane;        assign o_a[1]     = bus_b.A_lane;
    assign o_d[0]     = bus_a.D_lane;        assign o_d[1]     = bus_b.D_lane;
    assign o_sel[0]   = bus_a.sel_bank;      assign o_sel[1]   = bus_b.sel_bank;
    assign o_wen[0]   = bus_a.w_enable_bank; assign o_wen[1]   = bus_b.w_enable_bank;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input int k, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d @%0t: got %h expected %h", name, k, $time, act, exp);
        end
    endtask

    // Reference model: pass phase 0=idle 1=accepting 2=final cycle, plus the last written group.
    int               m_groups [2] = '{16, 32};
    int               m_phase  [2];
    int               m_g      [2];
    int               m_last_g [2];
    logic [16*DW-1:0] m_last_d [2];
    bit               m_wr     [2];
    int               dut_wcnt [2];

    function automatic int digit_rot(input int g);
        int s = 0;
        int x = g;
        while (x > 0) begin
            s += x % 16;
            x  = x / 16;
        end
        return s % 16;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [79:0]       exp_sel;
            logic [16*MAW-1:0] exp_a;
            int                r;
            int                nph;
            if (!rst_n) begin
                m_phase[k] = 0; m_g[k] = 0; m_last_g[k] = 0;
                m_last_d[k] = '0; m_wr[k] = 0; dut_wcnt[k] = 0;
            end
            r = digit_rot(m_last_g[k]);
            for (int b = 0; b < 16; b++) begin
                exp_sel[b*5 +: 5] = m_wr[k] ? 5'((b - r + 16) % 16) : 5'd16;
                exp_a[b*MAW +: MAW] = MAW'(m_last_g[k]);
            end
            chk("in_ready", k, o_ready[k], m_phase[k] == 1);
            chk("busy",     k, o_busy[k],  m_phase[k] != 0);
            chk("done",     k, o_done[k],  m_phase[k] == 2);
            chk("w_enable", k, o_wen[k],   m_wr[k] ? 16'hFFFF : 16'h0000);
            chk("sel_bank", k, o_sel[k],   exp_sel);
            chk("A_lane",   k, o_a[k],     exp_a);
            chk("D_lane",   k, o_d[k],     m_last_d[k]);

            if (o_wen[k] != 16'h0) dut_wcnt[k]++;
            if (rst_n && m_phase[k] == 2) chk("writes_per_pass", k, dut_wcnt[k], m_groups[k]);

            if (rst_n && m_wr[k]) begin
                if (m_last_g[k] == 0 || m_last_g[k] == 31) begin
                    for (int b = 0; b < 16; b++) chk("lit_identity_sel", k, o_sel[k][b*5 +: 5], b);
                end
                if (m_last_g[k] == 1) begin
                    chk("lit_g1_sel0",  k, o_sel[k][0 +: 5],  15);
                    chk("lit_g1_sel1",  k, o_sel[k][5 +: 5],  0);
                    chk("lit_g1_sel15", k, o_sel[k][75 +: 5], 14);
                    chk("lit_g1_addr",  k, o_a[k][0 +: MAW],  1);
                end
                if (m_last_g[k] == 15) chk("lit_g15_sel0", k, o_sel[k][0 +: 5], 1);
                if (m_last_g[k] == 17) begin
                    chk("lit_g17_sel2", k, o_sel[k][10 +: 5], 0);
                    chk("lit_g17_sel1", k, o_sel[k][5 +: 5],  15);
                end
            end

            if (rst_n) begin
                nph = m_phase[k];
                m_wr[k] = 0;
                if (m_phase[k] == 0 && start_s) begin
                    nph = 1; m_g[k] = 0; dut_wcnt[k] = 0;
                end else if (m_phase[k] == 1 && in_valid_s) begin
                    m_wr[k] = 1;
                    m_last_g[k] = m_g[k];
                    m_last_d[k] = in_data_s;
                    m_g[k]++;
                    if (m_g[k] == m_groups[k]) nph = 2;
                end else if (m_phase[k] == 2) begin
                    nph = 0;
                end
                m_phase[k] = nph;
            end
        end
    end

    function automatic logic [16*DW-1:0] rand_data();
        logic [16*DW-1:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [16*DW-1:0] lane_pattern();
        logic [16*DW-1:0] v;
        for (int j = 0; j < 16; j++) v[j*DW +: DW] = DW'(16'h0100 + j);
        return v;
    endfunction

    task automatic run_pass(input int vpct, input int spct, input bit patterned);
        int cyc;
        bit first = patterned;
        @(posedge clk); #1 start_s = 1'b1; in_valid_s = 1'b0;
        @(posedge clk); #1 start_s = 1'b0;
        cyc = 0;
        while ((bus_a.busy || bus_b.busy) && cyc < 400) begin
            in_valid_s = ($urandom_range(99) < vpct);
            in_data_s  = first ? lane_pattern() : rand_data();
            if (in_valid_s) first = 1'b0;
            start_s    = ($urandom_range(99) < spct) && bus_b.busy;
            @(posedge clk); #1;
            cyc++;
        end
        start_s = 1'b0; in_valid_s = 1'b0;
        if (cyc >= 400) begin
            n_checks++; n_err++;
            $display("FAIL pass_timeout: still busy after %0d cycles, required idle", cyc);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        repeat (4) begin
            @(posedge clk); #1 in_valid_s = 1'b1; in_data_s = rand_data();
        end
        @(posedge clk); #1 in_valid_s = 1'b0;

        run_pass(100, 0, 1'b1);
        run_pass(50, 10, 1'b0);
        run_pass(70, 25, 1'b0);
        run_pass(30, 5, 1'b0);

        @(posedge clk); #1 start_s = 1'b1;
        @(posedge clk); #1 start_s = 1'b0;
        repeat (10) begin
            in_valid_s = 1'b1; in_data_s = rand_data();
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) begin
            in_valid_s = 1'b1; in_data_s = rand_data();
            @(posedge clk); #1;
        end
        in_valid_s = 1'b0;

        run_pass(80, 0, 1'b0);
        run_pass(100, 15, 1'b0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
